// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Host request front-end for the SPI master. Buffers read/write requests in a
// small FIFO, issues them one at a time as packed {wr, addr, wdata} commands,
// and returns exactly one in-order response per read (data or timeout).
//
// Optional build macro: SPI_SEQ_STATS_EN
//    Adds saturating 16-bit counters stat_wr_cnt, stat_rd_cnt, stat_err_cnt.
//
// FSM states:
//    state     | meaning
//    ----------+-----------------------------------------------------------
//    S_IDLE    | no command in flight; pops the FIFO head when non-empty
//    S_ISSUE   | cmd_vld held with stable cmd_out until cmd_rdy accepts it
//    S_WAIT_RD | read accepted by master; waiting for read data or timeout

module spi_cmd_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_vld,
   output logic                    req_rdy,
   input  logic                    req_wr,
   input  logic [DATA_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic [2*DATA_WIDTH:0]   cmd_out,
   output logic                    cmd_vld,
   input  logic                    cmd_rdy,
   input  logic                    m_read_vld,
   input  logic [DATA_WIDTH-1:0]   m_read_data,
   output logic                    rsp_vld,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_err,
`ifdef SPI_SEQ_STATS_EN
   output logic [15:0]             stat_wr_cnt,
   output logic [15:0]             stat_rd_cnt,
   output logic [15:0]             stat_err_cnt,
`endif
   output logic                    busy
);

   localparam int CMD_W  = 2*DATA_WIDTH + 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT_RD = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [CMD_W-1:0]      fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [CMD_W-1:0]      push_word;

   // FSM / output registers
   state_t                state_q, state_d;
   logic [CMD_W-1:0]      cmd_out_q, cmd_out_d;
   logic                  cmd_vld_q, cmd_vld_d;
   logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   assign req_rdy    = !fifo_full;
   assign push       = req_vld && !fifo_full;

   // Read commands carry a zero data field so the host's don't-care wdata
   // never leaks onto the SPI bus.
   assign push_word  = {req_wr, req_addr, (req_wr ? req_wdata : {DATA_WIDTH{1'b0}})};

   // Pointer and occupancy update; full blocks push even when popping
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointer, count and storage registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_word;
         end
      end
   end

   // Next-state and output decode for the issue/wait sequencer
   always_comb begin
      state_d    = state_q;
      cmd_out_d  = cmd_out_q;
      cmd_vld_d  = cmd_vld_q;
      tmo_cnt_d  = tmo_cnt_q;
      rsp_vld_d  = 1'b0;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               cmd_out_d = fifo_mem_q[rd_ptr_q];
               cmd_vld_d = 1'b1;
               state_d   = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (cmd_vld_q && cmd_rdy) begin
               cmd_vld_d = 1'b0;
               if (cmd_out_q[CMD_W-1]) begin
                  state_d = S_IDLE;
               end else begin
                  tmo_cnt_d = '0;
                  state_d   = S_WAIT_RD;
               end
            end
         end

         S_WAIT_RD: begin
            // Data arriving on the last timeout cycle still counts as success.
            if (m_read_vld) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = m_read_data;
               rsp_err_d  = 1'b0;
               state_d    = S_IDLE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end

         default: begin
            state_d   = S_IDLE;
            cmd_vld_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cmd_out_q  <= '0;
         cmd_vld_q  <= 1'b0;
         tmo_cnt_q  <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_out_q  <= cmd_out_d;
         cmd_vld_q  <= cmd_vld_d;
         tmo_cnt_q  <= tmo_cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign cmd_out  = cmd_out_q;
   assign cmd_vld  = cmd_vld_q;
   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;
   assign busy     = !fifo_empty || (state_q != S_IDLE);

`ifdef SPI_SEQ_STATS_EN
   logic        wr_fire;
   logic        rd_ok;
   logic        rd_tmo;
   logic [15:0] stat_wr_q;
   logic [15:0] stat_rd_q;
   logic [15:0] stat_err_q;

   assign wr_fire = (state_q == S_ISSUE) && cmd_vld_q && cmd_rdy && cmd_out_q[CMD_W-1];
   assign rd_ok   = (state_q == S_WAIT_RD) && m_read_vld;
   assign rd_tmo  = (state_q == S_WAIT_RD) && !m_read_vld && (tmo_cnt_q == TMO_LAST);

   // Saturating activity counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_wr_q  <= '0;
         stat_rd_q  <= '0;
         stat_err_q <= '0;
      end else begin
         if (wr_fire && (stat_wr_q != 16'hFFFF)) begin
            stat_wr_q <= stat_wr_q + 16'd1;
         end
         if (rd_ok && (stat_rd_q != 16'hFFFF)) begin
            stat_rd_q <= stat_rd_q + 16'd1;
         end
         if (rd_tmo && (stat_err_q != 16'hFFFF)) begin
            stat_err_q <= stat_err_q + 16'd1;
         end
      end
   end

   assign stat_wr_cnt  = stat_wr_q;
   assign stat_rd_cnt  = stat_rd_q;
   assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: vector table for the write/read path,
// then directed sequences for FIFO full, timeout, data-vs-timeout race,
// asynchronous reset and (when SPI_SEQ_STATS_EN is defined) the counters.

module tb_spi_cmd_sequencer;

   logic        clk;
   logic        rst;
   logic        req_vld;
   logic        req_rdy;
   logic        req_wr;
   logic [7:0]  req_addr;
   logic [7:0]  req_wdata;
   logic [16:0] cmd_out;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        m_read_vld;
   logic [7:0]  m_read_data;
   logic        rsp_vld;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        busy;
`ifdef SPI_SEQ_STATS_EN
   logic [15:0] stat_wr_cnt;
   logic [15:0] stat_rd_cnt;
   logic [15:0] stat_err_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   spi_cmd_sequencer #(
      .DATA_WIDTH     (8),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .cmd_out     (cmd_out),
      .cmd_vld     (cmd_vld),
      .cmd_rdy     (cmd_rdy),
      .m_read_vld  (m_read_vld),
      .m_read_data (m_read_data),
      .rsp_vld     (rsp_vld),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
`ifdef SPI_SEQ_STATS_EN
      .stat_wr_cnt (stat_wr_cnt),
      .stat_rd_cnt (stat_rd_cnt),
      .stat_err_cnt(stat_err_cnt),
`endif
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        vld;
      logic        wr;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic        crdy;
      logic        mrv;
      logic [7:0]  mrd;
      logic        e_rdy;
      logic        e_cvld;
      logic [16:0] e_cout;
      logic        e_rvld;
      logic [7:0]  e_rdata;
      logic        e_rerr;
      logic        e_busy;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
      req_vld   = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_vld   = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while (busy && n < bound) begin
         tick();
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   function automatic vec_t mk(input logic vld, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic crdy, input logic mrv,
                               input logic [7:0] mrd, input logic e_rdy, input logic e_cvld,
                               input logic [16:0] e_cout, input logic e_rvld,
                               input logic [7:0] e_rdata, input logic e_rerr, input logic e_busy);
      vec_t v;
      v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata; v.crdy = crdy;
      v.mrv = mrv; v.mrd = mrd; v.e_rdy = e_rdy; v.e_cvld = e_cvld; v.e_cout = e_cout;
      v.e_rvld = e_rvld; v.e_rdata = e_rdata; v.e_rerr = e_rerr; v.e_busy = e_busy;
      return v;
   endfunction

   initial begin
      logic [16:0] exp_cmd [5];
      int          k;
      int          n;
      logic        seen_rsp;
      logic        seen_cmd;
      logic [16:0] held;

      // write 0x12/0xA5, then read 0x12 returned five cycles after fire
      vecs[0]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h00000,0,8'h00,0,0);
      vecs[1]  = mk(1,1,8'h12,8'hA5,1,0,8'h00, 1,0,17'h00000,0,8'h00,0,1);
      vecs[2]  = mk(1,0,8'h12,8'hFF,1,0,8'h00, 1,1,17'h112A5,0,8'h00,0,1);
      vecs[3]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h112A5,0,8'h00,0,1);
      vecs[4]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,1,17'h01200,0,8'h00,0,1);
      vecs[5]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'h00,0,1);
      vecs[6]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'h00,0,1);
      vecs[7]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'h00,0,1);
      vecs[8]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'h00,0,1);
      vecs[9]  = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'h00,0,1);
      vecs[10] = mk(0,0,8'h00,8'h00,1,1,8'hA5, 1,0,17'h01200,1,8'hA5,0,0);
      vecs[11] = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'hA5,0,0);
      vecs[12] = mk(0,0,8'h00,8'h00,1,1,8'h77, 1,0,17'h01200,0,8'hA5,0,0);
      vecs[13] = mk(0,0,8'h00,8'h00,1,0,8'h00, 1,0,17'h01200,0,8'hA5,0,0);

      rst = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      cmd_rdy = 1'b0; m_read_vld = 1'b0; m_read_data = '0;
      #3 rst = 1'b1;
      tick();
      tick();
      check("rst_req_rdy",  32'(req_rdy),  32'd1);
      check("rst_cmd_vld",  32'(cmd_vld),  32'd0);
      check("rst_cmd_out",  32'(cmd_out),  32'd0);
      check("rst_rsp_vld",  32'(rsp_vld),  32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_err",  32'(rsp_err),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      rst = 1'b0;
      tick();

      // ---------------- vector table ----------------
      for (int i = 0; i < 14; i++) begin
         req_vld = vecs[i].vld; req_wr = vecs[i].wr; req_addr = vecs[i].addr;
         req_wdata = vecs[i].wdata; cmd_rdy = vecs[i].crdy;
         m_read_vld = vecs[i].mrv; m_read_data = vecs[i].mrd;
         tick();
         check($sformatf("vec%0d_req_rdy", i),  32'(req_rdy),  32'(vecs[i].e_rdy));
         check($sformatf("vec%0d_cmd_vld", i),  32'(cmd_vld),  32'(vecs[i].e_cvld));
         check($sformatf("vec%0d_cmd_out", i),  32'(cmd_out),  32'(vecs[i].e_cout));
         check($sformatf("vec%0d_rsp_vld", i),  32'(rsp_vld),  32'(vecs[i].e_rvld));
         check($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rdata));
         check($sformatf("vec%0d_rsp_err", i),  32'(rsp_err),  32'(vecs[i].e_rerr));
         check($sformatf("vec%0d_busy", i),     32'(busy),     32'(vecs[i].e_busy));
      end
      req_vld = 1'b0; m_read_vld = 1'b0;

      // ---------------- FIFO full with cmd_rdy low ----------------
      cmd_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_cmd[i] = {1'b1, 8'(8'h20 + i), 8'(8'h50 + i)};
         check($sformatf("full_rdy_before_push%0d", i), 32'(req_rdy), 32'd1);
         req_vld = 1'b1; req_wr = 1'b1;
         req_addr = 8'(8'h20 + i); req_wdata = 8'(8'h50 + i);
         tick();
      end
      // sixth request offered while full: must be refused
      req_addr = 8'h2F; req_wdata = 8'h5F;
      held = cmd_out;
      check("full_head_cmd", 32'(held), 32'(exp_cmd[0]));
      for (int j = 0; j < 3; j++) begin
         check($sformatf("full_req_rdy%0d", j), 32'(req_rdy), 32'd0);
         check($sformatf("full_cmd_vld%0d", j), 32'(cmd_vld), 32'd1);
         check($sformatf("full_cmd_stable%0d", j), 32'(cmd_out), 32'(held));
         tick();
      end
      req_vld = 1'b0;
      cmd_rdy = 1'b1;
      k = 1;
      seen_rsp = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (rsp_vld) seen_rsp = 1'b1;
         if (cmd_vld) begin
            if (k < 5) check($sformatf("full_drain_cmd%0d", k), 32'(cmd_out), 32'(exp_cmd[k]));
            k++;
         end
      end
      check("full_drain_count", 32'(k), 32'd5);
      check("full_no_rsp_for_writes", 32'(seen_rsp), 32'd0);
      check("full_busy_after", 32'(busy), 32'd0);

      // ---------------- read timeout then queued write ----------------
      push(1'b0, 8'h34, 8'h99);
      push(1'b1, 8'h35, 8'h66);
      check("tmo_read_cmd", 32'(cmd_out), 32'h03400);
      check("tmo_read_vld", 32'(cmd_vld), 32'd1);
      tick();                              // read fires on this edge
      n = 0;
      seen_cmd = 1'b0;
      while (!rsp_vld && n < 400) begin
         tick();
         n++;
         if (cmd_vld) seen_cmd = 1'b1;
      end
      check("tmo_latency", 32'(n), 32'd255);
      check("tmo_rsp_err", 32'(rsp_err), 32'd1);
      check("tmo_rsp_data", 32'(rsp_data), 32'd0);
      check("tmo_no_issue_in_wait", 32'(seen_cmd), 32'd0);
      tick();
      check("tmo_rsp_pulse", 32'(rsp_vld), 32'd0);
      check("tmo_next_cmd_vld", 32'(cmd_vld), 32'd1);
      check("tmo_next_cmd", 32'(cmd_out), 32'h13566);
      wait_idle("tmo_idle", 10);

      // ---------------- data on the final timeout cycle ----------------
      push(1'b0, 8'h40, 8'h00);
      tick();
      check("race_read_cmd", 32'(cmd_out), 32'h04000);
      tick();                              // read fires on this edge
      seen_rsp = 1'b0;
      for (int j = 1; j < 255; j++) begin
         tick();
         if (rsp_vld) seen_rsp = 1'b1;
      end
      check("race_no_early_rsp", 32'(seen_rsp), 32'd0);
      m_read_vld = 1'b1; m_read_data = 8'h3C;
      tick();
      m_read_vld = 1'b0;
      check("race_rsp_vld", 32'(rsp_vld), 32'd1);
      check("race_rsp_err", 32'(rsp_err), 32'd0);
      check("race_rsp_data", 32'(rsp_data), 32'h3C);
      tick();
      check("race_single_pulse", 32'(rsp_vld), 32'd0);
      check("race_busy", 32'(busy), 32'd0);

      // ---------------- asynchronous reset in ISSUE ----------------
      cmd_rdy = 1'b0;
      push(1'b1, 8'h50, 8'h01);
      push(1'b1, 8'h51, 8'h02);
      push(1'b0, 8'h52, 8'h00);
      check("arst_pre_cmd_vld", 32'(cmd_vld), 32'd1);
      check("arst_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_cmd_vld", 32'(cmd_vld), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_cmd_out", 32'(cmd_out), 32'd0);
      check("arst_rsp_data", 32'(rsp_data), 32'd0);
      cmd_rdy = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("arst_req_rdy", 32'(req_rdy), 32'd1);
      seen_cmd = 1'b0; seen_rsp = 1'b0;
      for (int j = 0; j < 6; j++) begin
         tick();
         if (cmd_vld || busy) seen_cmd = 1'b1;
         if (rsp_vld) seen_rsp = 1'b1;
      end
      check("arst_no_cmd_after", 32'(seen_cmd), 32'd0);
      check("arst_no_rsp_after", 32'(seen_rsp), 32'd0);

`ifdef SPI_SEQ_STATS_EN
      // ---------------- statistics counters ----------------
      check("stat_wr_reset",  32'(stat_wr_cnt),  32'd0);
      check("stat_rd_reset",  32'(stat_rd_cnt),  32'd0);
      check("stat_err_reset", 32'(stat_err_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         push(1'b1, 8'(8'h60 + i), 8'(8'h10 + i));
         wait_idle($sformatf("stat_wr_idle%0d", i), 10);
      end
      for (int i = 0; i < 2; i++) begin
         push(1'b0, 8'(8'h70 + i), 8'h00);
         tick();                           // pop to ISSUE
         tick();                           // fire
         tick();
         m_read_vld = 1'b1; m_read_data = 8'(8'hB0 + i);
         tick();
         m_read_vld = 1'b0;
         check($sformatf("stat_rd_rsp%0d", i), 32'(rsp_data), 32'(8'(8'hB0 + i)));
         wait_idle($sformatf("stat_rd_idle%0d", i), 10);
      end
      push(1'b0, 8'h7F, 8'h00);
      wait_idle("stat_tmo_idle", 300);
      check("stat_wr_cnt",  32'(stat_wr_cnt),  32'd3);
      check("stat_rd_cnt",  32'(stat_rd_cnt),  32'd2);
      check("stat_err_cnt", 32'(stat_err_cnt), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
